btn_dir_ctrl: RTL



---
 rtl/btn_dir_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/btn_dir_ctrl.sv
// Direction-button turn controller: edge-detects debounced buttons, filters duplicate/reversal
// turns and buffers pending turns until the game step. Define BTN_TURN_QUEUE_EN for a 2-deep turn queue.
module btn_dir_ctrl #(
  parameter logic [1:0] START_DIR = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       step,
  output logic [1:0] dir,
  output logic       turn_acc,
  output logic [1:0] pending
);

  logic [3:0] lvl;
  logic [3:0] prev_lvl;
  logic [3:0] rise;
  logic       cand_valid;
  logic [1:0] cand;
  logic [1:0] ref_dir;
  logic       accept;
  logic       push;
  logic       pop;
  logic [1:0] nxt_dir;

  assign lvl  = {btn_left, btn_down, btn_right, btn_up};
  assign rise = lvl & ~prev_lvl;

  // Bit index order doubles as priority: up > right > down > left.
  always_comb begin
    cand_valid = |rise;
    cand       = 2'b11;
    if (rise[0])      cand = 2'b00;
    else if (rise[1]) cand = 2'b01;
    else if (rise[2]) cand = 2'b10;
  end

  assign accept = cand_valid && (cand != ref_dir) && (cand != (ref_dir ^ 2'b10));

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_lvl <= 4'b0000;
      turn_acc <= 1'b0;
      dir      <= START_DIR;
    end else begin
      prev_lvl <= lvl;
      turn_acc <= push;
      dir      <= nxt_dir;
    end
  end

`ifdef BTN_TURN_QUEUE_EN
  logic [1:0] q_head;
  logic [1:0] q_tail;
  logic [1:0] cnt;
  logic [1:0] nxt_head;
  logic [1:0] nxt_tail;
  logic [1:0] nxt_cnt;

  // Reference is the most recently queued turn so the chain of turns stays legal.
  assign ref_dir = (cnt == 2'd0) ? dir : ((cnt == 2'd1) ? q_head : q_tail);
  assign pop     = step && (cnt != 2'd0);
  assign push    = accept && ((cnt != 2'd2) || pop);
  assign pending = cnt;

  always_comb begin
    nxt_dir  = dir;
    nxt_head = q_head;
    nxt_tail = q_tail;
    nxt_cnt  = cnt;
    case ({push, pop})
      2'b10: begin
        if (cnt == 2'd0) nxt_head = cand;
        else             nxt_tail = cand;
        nxt_cnt = cnt + 2'd1;
      end
      2'b01: begin
        nxt_dir  = q_head;
        nxt_head = q_tail;
        nxt_tail = 2'b00;
        nxt_cnt  = cnt - 2'd1;
      end
      2'b11: begin
        nxt_dir = q_head;
        if (cnt == 2'd1) begin
          nxt_head = cand;
        end else begin
          nxt_head = q_tail;
          nxt_tail = cand;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_head <= 2'b00;
      q_tail <= 2'b00;
      cnt    <= 2'd0;
    end else begin
      q_head <= nxt_head;
      q_tail <= nxt_tail;
      cnt    <= nxt_cnt;
    end
  end
`else
  logic [1:0] pend_dir;
  logic       pend_valid;
  logic [1:0] nxt_pend_dir;
  logic       nxt_pend_valid;

  // Single slot: latest accepted turn overwrites the pending one and is never dropped.
  assign ref_dir = dir;
  assign pop     = step && pend_valid;
  assign push    = accept;
  assign pending = {1'b0, pend_valid};

  always_comb begin
    nxt_dir        = dir;
    nxt_pend_dir   = pend_dir;
    nxt_pend_valid = pend_valid;
    if (pop) begin
      nxt_dir        = pend_dir;
      nxt_pend_valid = 1'b0;
    end
    if (push) begin
      nxt_pend_dir   = cand;
      nxt_pend_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_dir   <= 2'b00;
      pend_valid <= 1'b0;
    end else begin
      pend_dir   <= nxt_pend_dir;
      pend_valid <= nxt_pend_valid;
    end
  end
`endif

endmodule
